// File: rtl/bnn_spi_pkg.sv
// Shared codes, state type and frame sizing for the BNN SPI status path.
// SPI_TX_PARITY_EN appends an odd-parity bit to every transmitted frame.
package bnn_spi_pkg;

  localparam logic [3:0] STATUS_IDLE       = 4'h0;
  localparam logic [3:0] STATUS_RX_IMG_RDY = 4'h1;
  localparam logic [3:0] STATUS_RX_IMG     = 4'h2;
  localparam logic [3:0] STATUS_BNN_BUSY   = 4'h4;
  localparam logic [3:0] STATUS_RESULT_RDY = 4'h8;
  localparam logic [3:0] STATUS_ERROR      = 4'hE;

  localparam logic [7:0] CMD_IMG_SEND_REQUEST = 8'hFE;
  localparam logic [7:0] CMD_CLEAR            = 8'hFD;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT
  } tx_state_t;

`ifdef SPI_TX_PARITY_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif

  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] bit_cnt_t;
  localparam bit_cnt_t FRAME_LAST     = bit_cnt_t'(FRAME_BITS - 1);
  localparam bit_cnt_t FRAME_BITS_CNT = bit_cnt_t'(FRAME_BITS);

  // Low nibble falls back to the "no result" marker while the BNN output is stale.
  function automatic logic [7:0] make_resp(input logic [3:0] status,
                                           input logic [3:0] digit,
                                           input logic       valid,
                                           input logic [3:0] no_result);
    return {status, (valid ? digit : no_result)};
  endfunction

endpackage

// File: rtl/spi_status_tx_if.sv
// Pin and controller-side signals of the SPI status transmitter.
interface spi_status_tx_if;
  logic       sclk;
  logic       cs_n;
  logic [3:0] status_code;
  logic [3:0] result_digit;
  logic       result_valid;
  logic       miso;
  logic       miso_oe;
  logic       byte_sent;
  logic       result_consumed;

  modport slave (
    input  sclk, cs_n, status_code, result_digit, result_valid,
    output miso, miso_oe, byte_sent, result_consumed
  );

  modport master (
    output sclk, cs_n, status_code, result_digit, result_valid,
    input  miso, miso_oe, byte_sent, result_consumed
  );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall pulses
// taken from the last two stages.
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  =  sync_reg[SYNC_STAGES-2] & ~sync_reg[SYNC_STAGES-1];
  assign fall  = ~sync_reg[SYNC_STAGES-2] &  sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/spi_status_tx.sv
// SPI mode-0 MSB-first status/result transmitter on MISO.
// Define SPI_TX_PARITY_EN for a 9-bit frame ending in odd parity.
module spi_status_tx
  import bnn_spi_pkg::*;
#(
  parameter int         SYNC_STAGES      = 2,
  parameter logic [3:0] NO_RESULT_NIBBLE = 4'hF
) (
  input logic            clk,
  input logic            rst_n,
  spi_status_tx_if.slave bus
);

  logic sclk_level_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_level;
  logic cs_rise;
  logic cs_fall;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.sclk),
    .level(sclk_level_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.cs_n),
    .level(cs_level),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  tx_state_t              state_reg, state_next;
  logic [FRAME_BITS-1:0]  tx_reg, tx_next;
  logic                   snap_valid_reg, snap_valid_next;
  bit_cnt_t               bit_cnt_reg, bit_cnt_next;
  logic                   load_pending_reg, load_pending_next;
  logic                   miso_reg, miso_next;
  logic                   miso_oe_reg, miso_oe_next;
  logic                   byte_sent_reg, byte_sent_next;
  logic                   consumed_reg, consumed_next;
  logic                   armed_reg;
  logic [SYNC_STAGES-1:0] flush_reg;

  logic [7:0]            resp;
  logic [FRAME_BITS-1:0] frame_word;

  assign resp = make_resp(bus.status_code, bus.result_digit, bus.result_valid,
                          NO_RESULT_NIBBLE);

`ifdef SPI_TX_PARITY_EN
  assign frame_word = {resp, ~^resp};
`else
  assign frame_word = resp;
`endif

  // The chain still holds its reset value for SYNC_STAGES cycles; trusting
  // cs_level before then would arm on a fake "high" and accept a fake fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_reg <= '0;
      armed_reg <= 1'b0;
    end else begin
      flush_reg <= {flush_reg[SYNC_STAGES-2:0], 1'b1};
      if (flush_reg[SYNC_STAGES-1] && cs_level) begin
        armed_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      tx_reg           <= '0;
      snap_valid_reg   <= 1'b0;
      bit_cnt_reg      <= '0;
      load_pending_reg <= 1'b0;
      miso_reg         <= 1'b0;
      miso_oe_reg      <= 1'b0;
      byte_sent_reg    <= 1'b0;
      consumed_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      tx_reg           <= tx_next;
      snap_valid_reg   <= snap_valid_next;
      bit_cnt_reg      <= bit_cnt_next;
      load_pending_reg <= load_pending_next;
      miso_reg         <= miso_next;
      miso_oe_reg      <= miso_oe_next;
      byte_sent_reg    <= byte_sent_next;
      consumed_reg     <= consumed_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    tx_next           = tx_reg;
    snap_valid_next   = snap_valid_reg;
    bit_cnt_next      = bit_cnt_reg;
    load_pending_next = load_pending_reg;
    miso_next         = 1'b0;
    miso_oe_next      = 1'b0;
    byte_sent_next    = 1'b0;
    consumed_next     = 1'b0;

    if (cs_rise) begin
      // Deselect overrides any sclk edge seen in the same cycle.
      state_next        = S_IDLE;
      bit_cnt_next      = '0;
      load_pending_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (armed_reg && cs_fall) begin
            state_next = S_LOAD;
          end
        end

        S_LOAD: begin
          tx_next           = frame_word;
          snap_valid_next   = bus.result_valid;
          bit_cnt_next      = '0;
          load_pending_next = 1'b0;
          miso_oe_next      = 1'b1;
          state_next        = S_SHIFT;
        end

        S_SHIFT: begin
          miso_oe_next = 1'b1;
          miso_next    = tx_reg[FRAME_BITS-1];
          if (sclk_rise) begin
            if (bit_cnt_reg == FRAME_LAST) begin
              byte_sent_next    = 1'b1;
              consumed_next     = snap_valid_reg;
              load_pending_next = 1'b1;
              bit_cnt_next      = '0;
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end else if (sclk_fall) begin
            // The fall closing a frame reloads instead of shifting.
            if (load_pending_reg) begin
              tx_next           = frame_word;
              snap_valid_next   = bus.result_valid;
              load_pending_next = 1'b0;
            end else if (bit_cnt_reg != '0 && bit_cnt_reg < FRAME_BITS_CNT) begin
              tx_next = {tx_reg[FRAME_BITS-2:0], 1'b0};
            end
          end
        end

        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  assign bus.miso            = miso_reg;
  assign bus.miso_oe         = miso_oe_reg;
  assign bus.byte_sent       = byte_sent_reg;
  assign bus.result_consumed = consumed_reg;

endmodule

// File: tb/tb_spi_status_tx.sv
// Host-side SPI model driving spi_status_tx; received bytes are scored
// against a queue of expected responses.
module tb_spi_status_tx;
  import bnn_spi_pkg::*;

  localparam int HALF = 8;

  logic clk;
  logic rst_n;

  spi_status_tx_if bus_if ();

  spi_status_tx #(
    .SYNC_STAGES     (2),
    .NO_RESULT_NIBBLE(4'hF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] status;
    logic [3:0] digit;
    logic       valid;
    logic [7:0] exp_byte;
    int         exp_consumed;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_q[$];
  logic       rx_bits[$];

  int checks = 0;
  int errors = 0;
  int sent_total = 0;
  int cons_total = 0;
  int orphan_total = 0;
  int oe_total = 0;

  always @(negedge clk) begin
    if (bus_if.byte_sent) sent_total++;
    if (bus_if.result_consumed) cons_total++;
    if (bus_if.result_consumed && !bus_if.byte_sent) orphan_total++;
    if (bus_if.miso_oe) oe_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // One CS frame of nbits sclk cycles; status_code changes before bit chg_bit.
  task automatic host_frame(input int nbits, input int chg_bit, input logic [3:0] chg_status,
                            output logic oe_mid);
    oe_mid = 1'b0;
    bus_if.cs_n = 1'b0;
    repeat (HALF) tick();
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) bus_if.status_code = chg_status;
      rx_bits.push_back(bus_if.miso);
      if (i == nbits - 1) oe_mid = bus_if.miso_oe;
      bus_if.sclk = 1'b1;
      repeat (HALF) tick();
      bus_if.sclk = 1'b0;
      repeat (HALF) tick();
    end
    bus_if.cs_n = 1'b1;
    repeat (2 * HALF) tick();
  endtask

  task automatic drain(input string tag);
    logic [7:0] b;
    logic [7:0] e;
`ifdef SPI_TX_PARITY_EN
    logic p;
`endif
    while (rx_bits.size() >= FRAME_BITS) begin
      b = '0;
      for (int k = 0; k < 8; k++) b = {b[6:0], rx_bits.pop_front()};
`ifdef SPI_TX_PARITY_EN
      p = rx_bits.pop_front();
`endif
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_extra: got byte %02h required none", tag, b);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_byte"}, {24'd0, b}, {24'd0, e});
`ifdef SPI_TX_PARITY_EN
        check({tag, "_parity"}, {31'd0, p}, {31'd0, ~^e});
`endif
        $display("frame %s: rx=%02h exp=%02h", tag, b, e);
      end
    end
    rx_bits.delete();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_missing: got %0d bytes short required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   s0, c0, o0;
    logic oe_mid;

    vecs[0] = '{4'h8, 4'h7, 1'b1, 8'h87, 1};
    vecs[1] = '{4'h4, 4'h3, 1'b0, 8'h4F, 0};
    vecs[2] = '{4'hE, 4'hA, 1'b1, 8'hEA, 1};
    vecs[3] = '{4'h0, 4'h0, 1'b1, 8'h00, 1};
    vecs[4] = '{4'h1, 4'h5, 1'b0, 8'h1F, 0};
    vecs[5] = '{4'h5, 4'h9, 1'b1, 8'h59, 1};

    rst_n = 1'b0;
    bus_if.cs_n = 1'b0;
    bus_if.sclk = 1'b0;
    bus_if.status_code = 4'h0;
    bus_if.result_digit = 4'h0;
    bus_if.result_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b1;
    tick();
    check("reset_miso", {31'd0, bus_if.miso}, 32'd0);
    check("reset_miso_oe", {31'd0, bus_if.miso_oe}, 32'd0);
    check("reset_byte_sent", {31'd0, bus_if.byte_sent}, 32'd0);
    check("reset_consumed", {31'd0, bus_if.result_consumed}, 32'd0);

    // Frame already in progress at reset release must be skipped.
    bus_if.status_code = 4'h8;
    bus_if.result_digit = 4'h7;
    bus_if.result_valid = 1'b1;
    o0 = oe_total;
    s0 = sent_total;
    for (int i = 0; i < FRAME_BITS; i++) begin
      bus_if.sclk = 1'b1;
      repeat (HALF) tick();
      bus_if.sclk = 1'b0;
      repeat (HALF) tick();
    end
    check("inflight_oe_cycles", o0 - oe_total + oe_total - o0 + (oe_total - o0), 32'd0);
    check("inflight_byte_sent", sent_total - s0, 32'd0);
    $display("frame inflight: oe_cycles=%0d byte_sent=%0d", oe_total - o0, sent_total - s0);
    bus_if.cs_n = 1'b1;
    repeat (2 * HALF) tick();

    for (int i = 0; i < 6; i++) begin
      bus_if.status_code = vecs[i].status;
      bus_if.result_digit = vecs[i].digit;
      bus_if.result_valid = vecs[i].valid;
      exp_q.push_back(vecs[i].exp_byte);
      s0 = sent_total;
      c0 = cons_total;
      host_frame(FRAME_BITS, -1, 4'h0, oe_mid);
      drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d_byte_sent", i), sent_total - s0, 32'd1);
      check($sformatf("vec%0d_consumed", i), cons_total - c0, vecs[i].exp_consumed);
      check($sformatf("vec%0d_oe", i), {31'd0, oe_mid}, 32'd1);
    end

    // Two bytes in one selection; the second reload sees the new status.
    bus_if.status_code = 4'h1;
    bus_if.result_digit = 4'h3;
    bus_if.result_valid = 1'b0;
    exp_q.push_back(8'h1F);
    exp_q.push_back(8'h2F);
    s0 = sent_total;
    c0 = cons_total;
    host_frame(2 * FRAME_BITS, 4, 4'h2, oe_mid);
    drain("b2b");
    check("b2b_byte_sent", sent_total - s0, 32'd2);
    check("b2b_consumed", cons_total - c0, 32'd0);

    // Deselect after 5 clocks: no pulses, driver released.
    bus_if.status_code = 4'h8;
    bus_if.result_digit = 4'h7;
    bus_if.result_valid = 1'b1;
    s0 = sent_total;
    c0 = cons_total;
    host_frame(5, -1, 4'h0, oe_mid);
    drain("partial");
    check("partial_oe_mid", {31'd0, oe_mid}, 32'd1);
    check("partial_oe_after", {31'd0, bus_if.miso_oe}, 32'd0);
    check("partial_byte_sent", sent_total - s0, 32'd0);
    check("partial_consumed", cons_total - c0, 32'd0);
    $display("frame partial: byte_sent=%0d consumed=%0d", sent_total - s0, cons_total - c0);

    bus_if.result_digit = 4'h3;
    exp_q.push_back(8'h83);
    s0 = sent_total;
    c0 = cons_total;
    host_frame(FRAME_BITS, -1, 4'h0, oe_mid);
    drain("after_partial");
    check("after_partial_byte_sent", sent_total - s0, 32'd1);
    check("after_partial_consumed", cons_total - c0, 32'd1);

    check("consumed_without_sent", orphan_total, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
